// File: rtl/demux_1_4_buf.sv
// 1-to-4 demultiplexer with a one-entry valid/ready holding register per channel.
// The channel comes from s, or from a round-robin pointer that only advances on accept.
module demux_1_4_buf #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode_rr,
  input  logic [1:0]         s,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [1:0]         rr_slot,
  output logic [CNT_W-1:0]   xfer_cnt
);

  logic [4*WIDTH-1:0] data_q, data_d;
  logic [3:0]         valid_q, valid_d;
  logic [1:0]         rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         target;
  logic               accept;

  assign target   = mode_rr ? rr_q : s;
  // A full channel still accepts when its consumer drains it on the same edge.
  assign in_ready = rst_n & (~valid_q[target] | out_ready[target]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~out_ready;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (target == 2'(i)) begin
          data_d[i*WIDTH +: WIDTH] = in_data;
          valid_d[i]               = 1'b1;
        end
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (mode_rr) begin
        rr_d = rr_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign rr_slot   = rr_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_1_4_buf.sv
// Directed bench for demux_1_4_buf: explicit and round-robin routing, back-pressure,
// drain-and-load, counter wrap and asynchronous reset.
module tb_demux_1_4_buf;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic               clk;
  logic               rst_n;
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic               mode_rr;
  logic [1:0]         s;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [1:0]         rr_slot;
  logic [CNT_W-1:0]   xfer_cnt;

  int errors = 0;
  int checks = 0;

  demux_1_4_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode_rr   (mode_rr),
    .s         (s),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_slot   (rr_slot),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic v, input logic m,
                               input logic [1:0] sel, input logic [3:0] ordy);
    in_data   = d;
    in_valid  = v;
    mode_rr   = m;
    s         = sel;
    out_ready = ordy;
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] chan(input int k);
    return out_data[k*WIDTH +: WIDTH];
  endfunction

  task automatic resetPulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    applyStimulus(4'd0, 1'b0, 1'b0, 2'd0, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_data", 32'(out_data), 32'h0);
    checkOutput("rst_rr", 32'(rr_slot), 32'h0);
    checkOutput("rst_cnt", 32'(xfer_cnt), 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    rst_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      applyStimulus(4'(k), 1'b1, 1'b0, 2'(k % 4), 4'b1111);
      #1;
      checkOutput("exp_in_ready", 32'(in_ready), 32'h1);
      tick();
      checkOutput("exp_data", 32'(chan(k % 4)), 32'(k));
      checkOutput("exp_valid", 32'(out_valid), 32'(1 << (k % 4)));
      checkOutput("exp_rr_hold", 32'(rr_slot), 32'h0);
    end
    checkOutput("exp_cnt", 32'(xfer_cnt), 32'd9);

    // s is driven opposite to the pointer to show it is ignored.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'(k), 1'b1, 1'b1, 2'(3 - (k % 4)), 4'b1111);
      #1;
      checkOutput("rr_slot_pre", 32'(rr_slot), 32'(k % 4));
      tick();
      checkOutput("rr_data", 32'(chan(k % 4)), 32'(k));
      checkOutput("rr_valid", 32'(out_valid), 32'(1 << (k % 4)));
    end
    checkOutput("rr_slot_end", 32'(rr_slot), 32'h0);
    checkOutput("rr_cnt", 32'(xfer_cnt), 32'd17);

    resetPulse();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'(k), 1'b1, 1'b1, 2'd0, 4'b1101);
      #1;
      checkOutput("bp_in_ready", 32'(in_ready), 32'h1);
      tick();
    end
    checkOutput("bp_valid4", 32'(out_valid), 32'b1010);
    checkOutput("bp_ch1", 32'(chan(1)), 32'd1);
    applyStimulus(4'd4, 1'b1, 1'b1, 2'd0, 4'b1101);
    tick();
    checkOutput("bp_valid5", 32'(out_valid), 32'b0011);
    checkOutput("bp_rr5", 32'(rr_slot), 32'd1);
    applyStimulus(4'd5, 1'b1, 1'b1, 2'd0, 4'b1101);
    #1;
    checkOutput("bp_stall_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("bp_stall_rr", 32'(rr_slot), 32'd1);
    checkOutput("bp_stall_ch1", 32'(chan(1)), 32'd1);
    checkOutput("bp_stall_cnt", 32'(xfer_cnt), 32'd5);
    checkOutput("bp_stall_valid", 32'(out_valid), 32'b0010);
    applyStimulus(4'd5, 1'b1, 1'b1, 2'd0, 4'b1111);
    #1;
    checkOutput("bp_release_ready", 32'(in_ready), 32'h1);
    tick();
    checkOutput("bp_reload_valid", 32'(out_valid), 32'b0010);
    checkOutput("bp_reload_ch1", 32'(chan(1)), 32'd5);
    checkOutput("bp_reload_rr", 32'(rr_slot), 32'd2);

    applyStimulus(4'd5, 1'b1, 1'b0, 2'd2, 4'b0000);
    tick();
    checkOutput("dl_fill_ch2", 32'(chan(2)), 32'd5);
    checkOutput("dl_fill_valid", 32'(out_valid), 32'b0110);
    applyStimulus(4'd9, 1'b1, 1'b0, 2'd2, 4'b0100);
    #1;
    checkOutput("dl_in_ready", 32'(in_ready), 32'h1);
    tick();
    checkOutput("dl_ch2", 32'(chan(2)), 32'd9);
    checkOutput("dl_valid", 32'(out_valid), 32'b0110);
    applyStimulus(4'd0, 1'b0, 1'b0, 2'd0, 4'b1111);
    tick();
    checkOutput("drain_valid", 32'(out_valid), 32'b0000);
    checkOutput("drain_retain", 32'(chan(2)), 32'd9);

    resetPulse();
    for (int k = 0; k < 255; k++) begin
      applyStimulus(4'(k), 1'b1, 1'b0, 2'd0, 4'b1111);
      tick();
    end
    checkOutput("cnt_255", 32'(xfer_cnt), 32'd255);
    applyStimulus(4'd15, 1'b1, 1'b0, 2'd0, 4'b1111);
    tick();
    checkOutput("cnt_wrap", 32'(xfer_cnt), 32'd0);

    resetPulse();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'(k + 10), 1'b1, 1'b1, 2'd0, 4'b0000);
      tick();
    end
    applyStimulus(4'd13, 1'b1, 1'b0, 2'd3, 4'b0000);
    tick();
    checkOutput("ar_full", 32'(out_valid), 32'b1111);
    checkOutput("ar_rr", 32'(rr_slot), 32'd3);
    checkOutput("ar_cnt", 32'(xfer_cnt), 32'd4);
    applyStimulus(4'd0, 1'b0, 1'b0, 2'd0, 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", 32'(out_valid), 32'b0000);
    checkOutput("ar_rr0", 32'(rr_slot), 32'd0);
    checkOutput("ar_cnt0", 32'(xfer_cnt), 32'd0);
    checkOutput("ar_in_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("ar_hold_valid", 32'(out_valid), 32'b0000);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
